// File: rtl/mux16_rr_feeder.sv
`default_nettype none
// ============================================================================
// Module   : mux16_rr_feeder
// Brief    : Two-channel round-robin front end that drives the 16-bit 2:1 mux
//            select and registers the chosen word behind a valid/ready stage.
// Revision : 1.0 - initial release
// ============================================================================
module mux16_rr_feeder #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic             sel,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic             r_prio;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_grant;
    logic             w_in_xfer;
    logic             w_out_hs;

    // Grant depends only on valids and state, never on data inputs.
    always_comb begin
        w_grant = r_prio;
        if (a_valid && !b_valid) begin
            w_grant = 1'b0;
        end else if (b_valid && !a_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_accept  = !r_valid || o_ready;
    assign w_in_xfer = w_accept && (w_grant ? b_valid : a_valid);
    assign w_out_hs  = r_valid && o_ready;

    assign sel      = w_grant;
    assign a_ready  = w_accept && !w_grant;
    assign b_ready  = w_accept &&  w_grant;
    assign o_data   = r_data;
    assign o_valid  = r_valid;
    assign xfer_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_in_xfer) begin
                r_data  <= w_grant ? b_data : a_data;
                r_valid <= 1'b1;
                r_prio  <= !w_grant;
            end else if (w_out_hs) begin
                r_valid <= 1'b0;
            end
            if (w_out_hs) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
